// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow pulses, synchronous flush and optional first-word-fall-through.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      w_inc,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      r_inc,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [CW-1:0]         count_nxt;
    logic                  wr_ok;
    logic                  rd_ok;

    // Handshake: a write is taken on any edge where w_inc is high and the
    // registered full flag is low; a read likewise with r_inc and !empty.
    // Rejected requests raise a one-cycle error pulse; clr overrides both.
    assign wr_ok = w_inc && !full  && !clr;
    assign rd_ok = r_inc && !empty && !clr;

    always_comb begin
        count_nxt = count;
        if (clr)
            count_nxt = '0;
        else if (wr_ok && !rd_ok)
            count_nxt = count + CW'(1);
        else if (rd_ok && !wr_ok)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            if (clr) begin
                wptr      <= '0;
                rptr      <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                overflow  <= w_inc && full;
                underflow <= r_inc && empty;
                if (wr_ok) wptr <= wptr + AW'(1);
                if (rd_ok) rptr <= rptr + AW'(1);
            end
        end
    end

    // Storage carries no reset; contents are meaningless once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wr_data;
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data = empty ? '0 : mem[rptr];
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rd_data <= '0;
                else if (clr)
                    rd_data <= '0;
                else if (rd_ok)
                    rd_data <= mem[rptr];
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: one registered-read and one FWFT instance
// share stimulus and are compared against a queue-based reference model.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       w_inc = 1'b0;
    logic       r_inc = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] rd_data0, rd_data1;
    logic       full0, empty0, almost_full0, almost_empty0, overflow0, underflow0;
    logic       full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
    logic [3:0] count0, count1;
    logic [5:0] flags0, flags1;

    assign flags0 = {full0, empty0, almost_full0, almost_empty0, overflow0, underflow0};
    assign flags1 = {full1, empty1, almost_full1, almost_empty1, overflow1, underflow1};

    int total = 0;
    int bad = 0;

    // Reference model: expected contents, last registered read word, error pulses.
    logic [7:0] exp_q[$];
    logic [7:0] m_rd = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .w_inc(w_inc), .wr_data(wr_data), .r_inc(r_inc),
        .rd_data(rd_data0), .full(full0), .empty(empty0), .almost_full(almost_full0),
        .almost_empty(almost_empty0), .count(count0), .overflow(overflow0), .underflow(underflow0)
    );

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .w_inc(w_inc), .wr_data(wr_data), .r_inc(r_inc),
        .rd_data(rd_data1), .full(full1), .empty(empty1), .almost_full(almost_full1),
        .almost_empty(almost_empty1), .count(count1), .overflow(overflow1), .underflow(underflow1)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] exp_flags();
        int n;
        n = exp_q.size();
        return {(n == 8), (n == 0), (n >= 6), (n <= 2), m_ovf, m_udf};
    endfunction

    function automatic logic [7:0] exp_fwft();
        if (exp_q.size() != 0) return exp_q[0];
        return 8'h00;
    endfunction

    function automatic logic [3:0] exp_count();
        return 4'(exp_q.size());
    endfunction

    // Drive one cycle from a falling edge, advance the model at the rising edge,
    // return at the next falling edge where outputs are sampled.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        int   n;
        logic was_full;
        logic was_empty;
        w_inc = w; wr_data = d; r_inc = r; clr = c;
        @(posedge clk);
        n = exp_q.size();
        was_full = (n == 8);
        was_empty = (n == 0);
        if (c) begin
            exp_q.delete();
            m_rd = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            m_ovf = w && was_full;
            m_udf = r && was_empty;
            if (r && !was_empty) m_rd = exp_q.pop_front();
            if (w && !was_full) exp_q.push_back(d);
        end
        @(negedge clk);
        w_inc = 1'b0; r_inc = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (flags0 !== 6'b010100) begin bad++; $display("FAIL reset_flags0 got=%b exp=%b", flags0, 6'b010100); end
        total++; if (flags1 !== 6'b010100) begin bad++; $display("FAIL reset_flags1 got=%b exp=%b", flags1, 6'b010100); end
        total++; if (count0 !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count0); end
        total++; if (rd_data0 !== 8'h00 || rd_data1 !== 8'h00) begin bad++; $display("FAIL reset_rd got=%h/%h exp=00/00", rd_data0, rd_data1); end
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (flags0 !== 6'b010100 || count0 !== 4'd0) begin bad++; $display("FAIL reset_idle got=%b/%0d exp=010100/0", flags0, count0); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            total++; if (count0 !== 4'(i)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count0, i); end
            total++; if (flags0 !== exp_flags()) begin bad++; $display("FAIL fill_flags i=%0d got=%b exp=%b", i, flags0, exp_flags()); end
            total++; if (rd_data1 !== 8'h01) begin bad++; $display("FAIL fill_fwft_head i=%0d got=%h exp=01", i, rd_data1); end
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        total++; if (overflow0 !== 1'b1 || count0 !== 4'd8) begin bad++; $display("FAIL ovf_pulse got=%b/%0d exp=1/8", overflow0, count0); end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (overflow0 !== 1'b0) begin bad++; $display("FAIL ovf_single got=%b exp=0", overflow0); end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (rd_data0 !== 8'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, rd_data0, 8'(i)); end
            total++; if (flags0 !== exp_flags()) begin bad++; $display("FAIL drain_flags i=%0d got=%b exp=%b", i, flags0, exp_flags()); end
        end
        total++; if (empty0 !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty0); end
    endtask

    task automatic test_underflow();
        step(1'b1, 8'h55, 1'b1, 1'b0);
        total++; if (underflow0 !== 1'b1 || count0 !== 4'd1) begin bad++; $display("FAIL udf_pulse got=%b/%0d exp=1/1", underflow0, count0); end
        total++; if (rd_data1 !== 8'h55) begin bad++; $display("FAIL udf_fwft got=%h exp=55", rd_data1); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (rd_data0 !== 8'h55) begin bad++; $display("FAIL udf_read got=%h exp=55", rd_data0); end
        total++; if (flags0 !== 6'b010100 || count0 !== 4'd0) begin bad++; $display("FAIL udf_after got=%b/%0d exp=010100/0", flags0, count0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] val;
        val = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, val, 1'b0, 1'b0);
            val = val + 8'd1;
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, val, 1'b1, 1'b0);
            total++; if (rd_data0 !== val - 8'd3) begin bad++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, rd_data0, val - 8'd3); end
            total++; if (count0 !== 4'd3 || flags0 !== 6'b000000) begin bad++; $display("FAIL stream_state i=%0d got=%0d/%b exp=3/000000", i, count0, flags0); end
            val = val + 8'd1;
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (rd_data0 !== val - 8'd1 || empty0 !== 1'b1) begin bad++; $display("FAIL stream_tail got=%h/%b exp=%h/1", rd_data0, empty0, val - 8'd1); end
    endtask

    task automatic test_fwft();
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        total++; if (empty1 !== 1'b0 || rd_data1 !== 8'h3C) begin bad++; $display("FAIL fwft_show got=%b/%h exp=0/3c", empty1, rd_data1); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (empty1 !== 1'b1 || rd_data1 !== 8'h00) begin bad++; $display("FAIL fwft_consume got=%b/%h exp=1/00", empty1, rd_data1); end
        total++; if (rd_data0 !== 8'h3C) begin bad++; $display("FAIL fwft_reg_read got=%h exp=3c", rd_data0); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (count0 !== 4'd5 || rd_data0 !== m_rd) begin bad++; $display("FAIL clr_pre got=%0d/%h exp=5/%h", count0, rd_data0, m_rd); end
        step(1'b1, 8'h77, 1'b0, 1'b1);
        total++; if (count0 !== 4'd0 || flags0 !== 6'b010100) begin bad++; $display("FAIL clr_state got=%0d/%b exp=0/010100", count0, flags0); end
        total++; if (rd_data0 !== 8'h00 || rd_data1 !== 8'h00) begin bad++; $display("FAIL clr_rd got=%h/%h exp=00/00", rd_data0, rd_data1); end
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++; if (count0 !== 4'd0 || flags0 !== 6'b010100) begin bad++; $display("FAIL arst_state got=%0d/%b exp=0/010100", count0, flags0); end
        total++; if (rd_data0 !== 8'h00 || rd_data1 !== 8'h00) begin bad++; $display("FAIL arst_rd got=%h/%h exp=00/00", rd_data0, rd_data1); end
        exp_q.delete();
        m_rd = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h99, 1'b0, 1'b0);
        total++; if (count0 !== 4'd1 || rd_data1 !== 8'h99) begin bad++; $display("FAIL arst_resume got=%0d/%h exp=1/99", count0, rd_data1); end
    endtask

    task automatic test_random();
        logic w;
        logic r;
        logic c;
        for (int i = 0; i < 400; i++) begin
            if ((i / 40) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            c = ($urandom_range(0, 63) == 0);
            step(w, 8'($urandom), r, c);
            total++; if (count0 !== exp_count() || count1 !== exp_count()) begin bad++; $display("FAIL rand_count i=%0d got=%0d/%0d exp=%0d", i, count0, count1, exp_count()); end
            total++; if (flags0 !== exp_flags() || flags1 !== exp_flags()) begin bad++; $display("FAIL rand_flags i=%0d got=%b/%b exp=%b", i, flags0, flags1, exp_flags()); end
            total++; if (rd_data0 !== m_rd) begin bad++; $display("FAIL rand_rd_reg i=%0d got=%h exp=%h", i, rd_data0, m_rd); end
            total++; if (rd_data1 !== exp_fwft()) begin bad++; $display("FAIL rand_rd_fwft i=%0d got=%h exp=%h", i, rd_data1, exp_fwft()); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_fwft();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO buffer: the same-domain companion to the dual-clock FIFO, for producer/consumer pairs sharing one clock. Adds occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, synchronous flush, and a selectable first-word-fall-through read mode. Sits between any two same-clock blocks that exchange data with the W_INC/R_INC increment handshake.

## Interface
- DATA_WIDTH, 8: word width in bits.
- DEPTH, 8: number of entries; power of two, ≥ 2.
- AF_LEVEL, DEPTH-2: ALMOST_FULL asserted when COUNT ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: ALMOST_EMPTY asserted when COUNT ≤ AE_LEVEL; range 0..DEPTH-1.
- FWFT, 0: 0 = registered read (data one cycle after R_INC); 1 = first-word-fall-through.
- CLK  in  1  single clock, all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous flush, active-high.
- W_INC  in  1  write request.
- WR_DATA  in  DATA_WIDTH  write data, sampled with W_INC.
- R_INC  in  1  read request.
- RD_DATA  out  DATA_WIDTH  read data.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT ≥ AF_LEVEL.
- ALMOST_EMPTY  out  1  COUNT ≤ AE_LEVEL.
- COUNT  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- OVERFLOW  out  1  one-cycle pulse: write rejected.
- UNDERFLOW  out  1  one-cycle pulse: read rejected.

## Operation
- Storage: DEPTH×DATA_WIDTH register array, not reset. Write/read pointers $clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Acceptance is evaluated against registered state at the clock edge:
  - write accepted iff W_INC && !FULL; writes WR_DATA at wptr, wptr+1.
  - read accepted iff R_INC && !EMPTY; rptr+1.
  - W_INC while FULL: no write, OVERFLOW=1 next cycle; rejected regardless of R_INC.
  - R_INC while EMPTY: no read, UNDERFLOW=1 next cycle; a simultaneous write is still accepted.
- COUNT: +1 write only, −1 read only, unchanged when both or neither are accepted.
- All flags are registered and derived from next COUNT, so they are valid the cycle after the operation, with no combinational path from inputs.
- FWFT=0: on an accepted read, RD_DATA <= mem[rptr] at that edge; otherwise RD_DATA holds its value.
- FWFT=1: RD_DATA = mem[rptr] when !EMPTY, 0 when EMPTY; R_INC consumes the presented word.
- CLR has priority over W_INC/R_INC. It zeroes the pointers and COUNT, sets the flags to reset values, does not raise OVERFLOW/UNDERFLOW, and in FWFT=0 clears RD_DATA to 0.

## Timing
- Reset values: COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=(AF_LEVEL==0 ? 1 : 0), i.e. 0 for legal values, OVERFLOW=0, UNDERFLOW=0, RD_DATA=0, pointers 0.
- RST asserts asynchronously mid-operation; all contents are logically lost. Deassertion takes effect at the next rising CLK.
- Write-to-EMPTY-deassert latency: 1 cycle. In FWFT=1 the word appears on RD_DATA in that same cycle.
- Read latency with FWFT=0: 1 cycle from R_INC edge to RD_DATA.
- Sustained throughput: 1 write + 1 read per cycle, at any occupancy 1..DEPTH-1.
- At FULL with W_INC && R_INC: the read is accepted, the write is rejected, COUNT becomes DEPTH-1, and OVERFLOW pulses.
- At EMPTY with W_INC && R_INC: the write is accepted, UNDERFLOW pulses, and COUNT becomes 1.

## Test plan
- Reset/fill (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2, FWFT=0): after RST release, write 1..8 back-to-back. Required: COUNT 1..8; ALMOST_EMPTY drops when COUNT=3; ALMOST_FULL rises when COUNT=6; FULL rises when COUNT=8; no OVERFLOW.
- Overflow: from full, W_INC with WR_DATA=0xAA for 1 cycle. Required: OVERFLOW pulses 1 cycle, COUNT stays 8. Then drain 8 reads: RD_DATA = 1..8 each one cycle after R_INC, 0xAA never appears, EMPTY=1 at the end.
- Underflow and simultaneous operation at empty: R_INC && W_INC with 0x55 while EMPTY. Required: UNDERFLOW pulse, COUNT=1. The next read returns 0x55.
- Wrap-around streaming: hold COUNT at 3 while writing and reading every cycle for 40 cycles with an incrementing pattern. Required: in-order data with no gaps, COUNT constant at 3, no error pulses.
- FWFT=1: single write of 0x3C to an empty FIFO. Required: EMPTY=0 and RD_DATA=0x3C on the next cycle without R_INC. A subsequent R_INC gives EMPTY=1 and RD_DATA=0.
- CLR/RST mid-operation: at COUNT=5, assert CLR together with W_INC. Required: next cycle COUNT=0, EMPTY=1, RD_DATA=0, no OVERFLOW. Repeat with asynchronous RST between edges: outputs take reset values immediately.
